host_status_tx: RTL

- Host-to-player UART transmitter: the return direction of the existing player-to-host serial link.
- After each guess is scored by the game logic, it snapshots the game status, frames it as a fixed 5-byte packet, and serializes it as 8N1, LSB first, on a single line.
- Sits on the host side between the game logic and the player-side receiver.
- Idle line is high.

---
 rtl/host_status_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/host_status_tx.sv
// Host-to-player status transmitter: snapshots the game status on `send`, frames it as a
// 5-byte packet (header, letter, counts, index, XOR checksum) and shifts it out as 8N1 UART.
module host_status_tx #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       send,
  input  logic [7:0] letter,
  input  logic [2:0] correct,
  input  logic [2:0] incorrect,
  input  logic [4:0] index_correct,
  input  logic       game_end,
  output logic       tx_serial,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [4:0][7:0] pkt_q, pkt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_d, busy_d, done_d, overrun_d;
  logic            bit_end;
  logic [7:0]      status_byte, index_byte, cur_byte;

  assign bit_end     = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign status_byte = {game_end, incorrect, 1'b0, correct};
  assign index_byte  = {3'b000, index_correct};

  always_comb begin
    case (byte_idx_q)
      3'd0:    cur_byte = pkt_q[0];
      3'd1:    cur_byte = pkt_q[1];
      3'd2:    cur_byte = pkt_q[2];
      3'd3:    cur_byte = pkt_q[3];
      default: cur_byte = pkt_q[4];
    endcase
  end

  // tx_d/busy_d/done_d describe the line in the *next* state, so the outputs come straight
  // from flops and the serial line cannot glitch.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pkt_d      = pkt_q;
    shift_d    = shift_q;
    tx_d       = tx_serial;
    busy_d     = busy;
    done_d     = 1'b0;
    overrun_d  = send && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (send) begin
          state_d    = START;
          clk_cnt_d  = '0;
          byte_idx_d = '0;
          pkt_d      = {HEADER ^ letter ^ status_byte ^ index_byte,
                        index_byte, status_byte, letter, HEADER};
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (bit_end) begin
          state_d   = DATA;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
          shift_d   = {1'b0, cur_byte[7:1]};
        end
      end
      DATA: begin
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q == 3'd4) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 3'd1;
            tx_d       = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      pkt_q      <= '0;
      shift_q    <= '0;
      tx_serial  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      pkt_q      <= pkt_d;
      shift_q    <= shift_d;
      tx_serial  <= tx_d;
      busy       <= busy_d;
      done       <= done_d;
      overrun    <= overrun_d;
    end
  end

endmodule
